// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer and flag controller of an async FIFO (write clock domain).
// Optional sticky overflow flag is built when the FIFO_WOVF_EN macro is defined.
module fifo_wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic                  ovf
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
  // XOR mask that inverts the two MSBs of a gray pointer: the "one lap ahead" image.
  localparam logic [PW-1:0] LAP_MASK = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level;
  logic          full_next;
  logic          almost_full_next;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  assign wr_accept = wr_en & ~full;
  assign waddr     = wbin[ADDR_WIDTH-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wbin_next        = wbin + {{(PW-1){1'b0}}, wr_accept};
    wgray_next       = wbin_next ^ (wbin_next >> 1);
    rbin             = gray2bin(rptr_sync);
    level            = wbin_next - rbin;
    full_next        = (wgray_next == (rptr_sync ^ LAP_MASK));
    almost_full_next = (level >= AF_THRESH);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
    end
  end

`ifdef FIFO_WOVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
